// File: rtl/show_sequencer.sv
// Show controller: runs the pattern blocks in turn, routes the active pattern's
// lights to the relays through a per-light minimum-dwell filter, and abandons hung patterns.
module show_sequencer #(
    parameter int unsigned NUM_PATTERNS = 4,
    parameter int unsigned CLKS_PER_MS  = 5000,
    parameter int unsigned GAP_MS       = 1000,
    parameter int unsigned MIN_DWELL_MS = 50,
    parameter int unsigned TIMEOUT_MS   = 120000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic [NUM_PATTERNS-1:0]           pat_finished,
    input  logic [8*NUM_PATTERNS-1:0]         pat_lights,
    output logic [NUM_PATTERNS-1:0]           pat_go,
    output logic [7:0]                        lights,
    output logic [$clog2(NUM_PATTERNS)-1:0]   active_idx,
    output logic                              timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_PATTERNS);
    localparam int unsigned PW    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int unsigned HW    = (MIN_DWELL_MS > 0) ? $clog2(MIN_DWELL_MS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_GAP
    } state_t;

    state_t                         state_q, state_d;
    logic [PW-1:0]                  presc_q, presc_d;
    logic                           tick;
    logic [31:0]                    ms_cnt_q, ms_cnt_d;
    logic [IDX_W-1:0]               active_idx_q, active_idx_d;
    logic [NUM_PATTERNS-1:0]        pat_go_q, pat_go_d;
    logic                           timeout_err_q, timeout_err_d;
    logic [7:0]                     lights_q, lights_d;
    logic [7:0][HW-1:0]             hold_q, hold_d;
    logic [NUM_PATTERNS-1:0][7:0]   pat_vec;
    logic [7:0]                     req;
    logic                           finish_hit;

    assign pat_vec    = pat_lights;
    assign finish_hit = pat_finished[active_idx_q];

    // Free-running millisecond prescaler, independent of the FSM.
    always_comb begin
        tick    = (presc_q == PW'(CLKS_PER_MS - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_comb begin
        state_d       = state_q;
        active_idx_d  = active_idx_q;
        timeout_err_d = timeout_err_q;
        req           = '0;

        if (state_q == S_RUN) begin
            req = pat_vec[active_idx_q];
        end

        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_START;
                S_START: state_d = S_RUN;
                S_RUN: begin
                    // A finish coinciding with the timeout wins.
                    if (finish_hit) begin
                        state_d = S_GAP;
                    end else if (ms_cnt_q == 32'(TIMEOUT_MS)) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_GAP;
                    end
                end
                S_GAP: begin
                    if (ms_cnt_q == 32'(GAP_MS)) begin
                        state_d      = S_START;
                        active_idx_d = (active_idx_q == IDX_W'(NUM_PATTERNS - 1)) ?
                                       '0 : active_idx_q + IDX_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d != state_q) begin
            ms_cnt_d = '0;
        end else if (tick && (ms_cnt_q != '1)) begin
            ms_cnt_d = ms_cnt_q + 32'd1;
        end else begin
            ms_cnt_d = ms_cnt_q;
        end

        pat_go_d = '0;
        if (state_d == S_START) begin
            pat_go_d[active_idx_d] = 1'b1;
        end
    end

    // Dwell filter: the live request is sampled when the hold time expires.
    always_comb begin
        lights_d = lights_q;
        hold_d   = hold_q;
        for (int unsigned k = 0; k < 8; k++) begin
            if ((req[3'(k)] != lights_q[3'(k)]) && (hold_q[3'(k)] == HW'(MIN_DWELL_MS))) begin
                lights_d[3'(k)] = req[3'(k)];
                hold_d[3'(k)]   = '0;
            end else if (tick && (hold_q[3'(k)] != HW'(MIN_DWELL_MS))) begin
                hold_d[3'(k)] = hold_q[3'(k)] + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            ms_cnt_q      <= '0;
            active_idx_q  <= '0;
            pat_go_q      <= '0;
            timeout_err_q <= 1'b0;
            lights_q      <= '0;
            hold_q        <= {8{HW'(MIN_DWELL_MS)}};
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            ms_cnt_q      <= ms_cnt_d;
            active_idx_q  <= active_idx_d;
            pat_go_q      <= pat_go_d;
            timeout_err_q <= timeout_err_d;
            lights_q      <= lights_d;
            hold_q        <= hold_d;
        end
    end

    assign pat_go      = pat_go_q;
    assign lights      = lights_q;
    assign active_idx  = active_idx_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_show_sequencer.sv
// Bench for show_sequencer: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a tick-count based reference model.
module tb_show_sequencer;

    localparam int NP    = 4;
    localparam int CLKS  = 4;
    localparam int GAPMS = 2;
    localparam int DWELL = 3;
    localparam int TOMS  = 20;

    localparam int P_IDLE  = 0;
    localparam int P_START = 1;
    localparam int P_RUN   = 2;
    localparam int P_GAP   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  fin;
    logic [31:0] plights;
    logic [3:0]  pat_go;
    logic [7:0]  lights;
    logic [1:0]  active_idx;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    bit chk_model = 1'b0;

    // Reference model: time is measured as a global count of ms ticks.
    int         m_cyc, m_T, m_t0, m_ph, m_idx;
    bit         m_terr;
    logic [7:0] m_lights;
    logic [3:0] m_go;
    int         m_last [8];

    typedef struct {
        int         n;
        logic       en;
        logic       fin0;
        logic [7:0] p0;
        logic [3:0] go;
        logic [7:0] lt;
        int         idx;
    } vec_t;

    vec_t tbl [9];

    show_sequencer #(
        .NUM_PATTERNS (NP),
        .CLKS_PER_MS  (CLKS),
        .GAP_MS       (GAPMS),
        .MIN_DWELL_MS (DWELL),
        .TIMEOUT_MS   (TOMS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .pat_finished (fin),
        .pat_lights   (plights),
        .pat_go       (pat_go),
        .lights       (lights),
        .active_idx   (active_idx),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_T = 0; m_t0 = 0; m_ph = P_IDLE; m_idx = 0;
        m_terr = 1'b0; m_lights = '0; m_go = '0;
        for (int k = 0; k < 8; k++) m_last[k] = -1000;
    endtask

    task automatic model_edge();
        bit         tk;
        int         ms, nph, nidx, t_old, hold;
        logic [7:0] rq;
        tk    = ((m_cyc % CLKS) == CLKS - 1);
        t_old = m_T;
        ms    = m_T - m_t0;
        nph   = m_ph;
        nidx  = m_idx;
        rq    = (m_ph == P_RUN) ? plights[8*m_idx +: 8] : 8'h00;
        if (!enable) nph = P_IDLE;
        else if (m_ph == P_IDLE) nph = P_START;
        else if (m_ph == P_START) nph = P_RUN;
        else if (m_ph == P_RUN) begin
            if (fin[m_idx]) nph = P_GAP;
            else if (ms == TOMS) begin m_terr = 1'b1; nph = P_GAP; end
        end else if (ms == GAPMS) begin
            nidx = (m_idx + 1) % NP;
            nph  = P_START;
        end
        if (tk) m_T++;
        for (int k = 0; k < 8; k++) begin
            hold = (t_old - m_last[k] > DWELL) ? DWELL : t_old - m_last[k];
            if (rq[k] != m_lights[k] && hold == DWELL) begin
                m_lights[k] = rq[k];
                m_last[k]   = m_T;
            end
        end
        if (nph != m_ph) m_t0 = m_T;
        m_ph  = nph;
        m_idx = nidx;
        m_go  = (nph == P_START) ? 4'(1 << nidx) : 4'h0;
        m_cyc++;
    endtask

    task automatic compare_model();
        check("m_pat_go", 32'(pat_go), 32'(m_go));
        check("m_lights", 32'(lights), 32'(m_lights));
        check("m_active_idx", 32'(active_idx), m_idx);
        check("m_timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (chk_model) compare_model();
    endtask

    task automatic wait_go(input logic [3:0] exp_go, input int exp_idx, input string name, input int budget);
        int n = 0;
        while (pat_go == 4'h0 && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(pat_go), 32'(exp_go));
        check({name, "_idx"}, 32'(active_idx), exp_idx);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         last_chg, changes, n;
        logic       prev;
        bit         any_go;

        tbl[0] = '{1, 1'b1, 1'b0, 8'hFF, 4'b0001, 8'h00, 0};
        tbl[1] = '{1, 1'b1, 1'b0, 8'hFF, 4'b0000, 8'h00, 0};
        tbl[2] = '{1, 1'b1, 1'b0, 8'hFF, 4'b0000, 8'hFF, 0};
        tbl[3] = '{9, 1'b1, 1'b0, 8'h00, 4'b0000, 8'hFF, 0};
        tbl[4] = '{1, 1'b1, 1'b0, 8'h00, 4'b0000, 8'h00, 0};
        tbl[5] = '{1, 1'b1, 1'b1, 8'h00, 4'b0000, 8'h00, 0};
        tbl[6] = '{6, 1'b1, 1'b0, 8'h00, 4'b0000, 8'h00, 0};
        tbl[7] = '{1, 1'b1, 1'b0, 8'h00, 4'b0010, 8'h00, 1};
        tbl[8] = '{1, 1'b1, 1'b0, 8'h00, 4'b0000, 8'h00, 1};

        enable = 1'b0; fin = '0; plights = '0;
        @(posedge clk);
        #1;
        apply_reset();
        check("rst_pat_go", 32'(pat_go), 0);
        check("rst_lights", 32'(lights), 0);
        check("rst_idx", 32'(active_idx), 0);
        check("rst_terr", 32'(timeout_err), 0);

        // Startup, dwell-limited change to dark, finish and gap to pattern 1.
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                enable  = tbl[r].en;
                fin     = {3'b000, tbl[r].fin0};
                plights = {24'h0, tbl[r].p0};
                step();
                check($sformatf("tbl%0d_go", r), 32'(pat_go), 32'(tbl[r].go));
                check($sformatf("tbl%0d_lights", r), 32'(lights), 32'(tbl[r].lt));
                check($sformatf("tbl%0d_idx", r), 32'(active_idx), tbl[r].idx);
                check($sformatf("tbl%0d_terr", r), 32'(timeout_err), 0);
            end
        end
        fin = '0;
        chk_model = 1'b1;
        compare_model();

        // Pattern 1 hangs: timeout, then pattern 2.
        plights = 32'h5A3C_A5F0;
        wait_go(4'b0100, 2, "timeout_go", 300);
        check("timeout_err_set", 32'(timeout_err), 1);

        // Non-active finish bits ignored, then pattern 2 and 3 finish; index wraps.
        step();
        fin = 4'b1010; step();
        fin = 4'b0000; repeat (3) step();
        fin = 4'b0100; step();
        fin = 4'b0000;
        wait_go(4'b1000, 3, "p3_go", 100);
        step();
        fin = 4'b1000; step();
        fin = 4'b0000;
        wait_go(4'b0001, 0, "wrap_go", 100);
        check("terr_sticky", 32'(timeout_err), 1);

        // Pattern 0 toggles light1 every clock; relay changes are spaced by the dwell.
        step();
        plights  = 32'h0;
        prev     = lights[0];
        last_chg = -1;
        changes  = 0;
        for (int c = 0; c < 60; c++) begin
            plights[0] = ~plights[0];
            step();
            if (lights[0] != prev) begin
                if (last_chg >= 0) check("dwell_spacing", 32'(c - last_chg >= (DWELL - 1) * CLKS + 2), 1);
                last_chg = c;
                changes++;
                prev = lights[0];
            end
        end
        check("dwell_changes", 32'(changes >= 3), 1);
        fin = 4'b0001; step();
        fin = 4'b0000;
        wait_go(4'b0010, 1, "p1_go", 100);
        step();
        fin = 4'b0010; step();
        fin = 4'b0000;
        wait_go(4'b0100, 2, "p2_go", 100);

        // Drop enable while pattern 2 runs, then resume it.
        plights = 32'h00FF_0000;
        repeat (20) step();
        enable = 1'b0;
        any_go = 1'b0;
        repeat (40) begin
            step();
            if (pat_go != 4'h0) any_go = 1'b1;
        end
        check("idle_no_go", 32'(any_go), 0);
        check("idle_dark", 32'(lights), 0);
        check("idle_idx_held", 32'(active_idx), 2);
        enable = 1'b1;
        wait_go(4'b0100, 2, "reenable_go", 10);
        repeat (16) step();

        // Asynchronous reset mid-show.
        rst_n = 1'b0;
        #2;
        check("midrst_go", 32'(pat_go), 0);
        check("midrst_lights", 32'(lights), 0);
        check("midrst_idx", 32'(active_idx), 0);
        check("midrst_terr", 32'(timeout_err), 0);
        enable = 1'b0; fin = '0; plights = '0;
        @(posedge clk);
        #1;
        apply_reset();

        // Finish arriving on the exact timeout cycle counts as a finish.
        enable = 1'b1;
        n = 0;
        while (!(m_ph == P_RUN && (m_T - m_t0) == TOMS) && n < 200) begin
            step();
            n++;
        end
        check("coinc_reached", 32'(n < 200), 1);
        fin = 4'b0001; step();
        fin = 4'b0000;
        check("coinc_no_terr", 32'(timeout_err), 0);
        wait_go(4'b0010, 1, "coinc_go", 100);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(63) != 0);
            fin    = ($urandom_range(15) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(2) == 0) plights = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/show_sequencer.md
# show_sequencer

Top-level show controller for the light display. It starts the pattern blocks one at a time with a one-cycle `go` pulse and waits for each block's one-cycle `finished` pulse. It routes the active pattern's 8 light requests to the relay outputs, inserting a dark gap between patterns. A per-light minimum-dwell filter protects the relays from fast toggling, and a watchdog recovers from a pattern that never finishes.

## Interface
- NUM_PATTERNS, 4, number of pattern blocks attached (2..8)
- CLKS_PER_MS, 5000, clk cycles per millisecond tick
- GAP_MS, 1000, dark gap between patterns, in ms (≥1)
- MIN_DWELL_MS, 50, minimum time a light output holds a value before it may change, in ms
- TIMEOUT_MS, 120000, maximum RUN time before a pattern is abandoned, in ms
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  show enable; level-sensitive
- pat_finished  in  NUM_PATTERNS  bit i is a one-cycle pulse from pattern i
- pat_lights  in  8*NUM_PATTERNS  light requests; bits [8i+7:8i] belong to pattern i, bit 0 = light1
- pat_go  out  NUM_PATTERNS  one-hot, one-cycle start pulse to pattern i
- lights  out  8  relay drive, registered; bit 0 = light1
- active_idx  out  $clog2(NUM_PATTERNS)  index of the current or next pattern
- timeout_err  out  1  sticky; set when any pattern times out

## Operation
- Prescaler: free-running counter 0..CLKS_PER_MS-1. `tick` is asserted for one cycle when the count equals CLKS_PER_MS-1, then the counter wraps to 0. It is never reset by the FSM.
- ms_cnt (32 bit): cleared on every state entry; increments on `tick`; saturates at its maximum.
- FSM states:
  - IDLE: the requested vector is 0.
    - Go to START when `enable`=1.
  - START: `pat_go[active_idx]`=1 for exactly this one cycle.
    - Always go to RUN next cycle.
  - RUN: requested = `pat_lights[active_idx]`.
    - `pat_finished[active_idx]`=1: go to GAP.
    - Otherwise, `ms_cnt`==TIMEOUT_MS: set `timeout_err`, go to GAP.
    - `pat_finished` bits of non-active patterns are ignored.
  - GAP: requested = 0.
    - When `ms_cnt`==GAP_MS, set `active_idx` = (`active_idx`+1) mod NUM_PATTERNS and go to START.
- `enable`=0 in any state: next state is IDLE, `active_idx` is held, and no `pat_go` is issued that cycle. Re-enable resumes at the held `active_idx` and restarts that pattern from START.
- A `pat_finished` pulse arriving in the same cycle as the timeout condition counts as a finish; `timeout_err` is not set.
- A `pat_finished` pulse during START, GAP or IDLE is ignored.
- Dwell filter: 8 independent channels. Channel k has a hold counter `hold_k` (saturating at MIN_DWELL_MS, incremented on `tick`).
  - If requested[k] ≠ lights[k] and `hold_k`==MIN_DWELL_MS: `lights[k]` takes the requested value on the next edge and `hold_k` clears to 0.
  - Otherwise `lights[k]` holds. The request is not latched; the value present when the dwell expires is the one applied.
- `timeout_err` clears only on reset.

## Timing
- Reset values:
  - state IDLE, `active_idx` 0, `pat_go` 0, `lights` 0x00, `timeout_err` 0, prescaler 0, `ms_cnt` 0.
  - All `hold_k` = MIN_DWELL_MS, so the first change is immediate.
- `enable` rising in IDLE: `pat_go` is asserted on the cycle after the edge where IDLE samples `enable`=1.
- `pat_go` is registered and high for exactly one clk cycle per START.
- Light latency: a change on `pat_lights` in RUN appears on `lights` one clk later when dwell is satisfied; otherwise at the first edge after `hold_k` reaches MIN_DWELL_MS.
- Finish to next go: finish cycle → GAP entry → GAP_MS ticks (±1 tick of prescaler phase) → START. The next `pat_go` asserts the cycle after GAP exits.
- Reset mid-show: all outputs return to reset values asynchronously; pattern blocks are reset by the same `rst_n`.

## Test plan
All scenarios use CLKS_PER_MS=4, GAP_MS=2, MIN_DWELL_MS=3, TIMEOUT_MS=20, NUM_PATTERNS=4.
- Reset, then `enable`=1 with pattern 0 driving 0xFF: `pat_go`=0001 for 1 cycle, then `lights`=0xFF one cycle after RUN entry.
- Pulse `pat_finished`[0] in RUN: `lights` go to 0x00 only after the 3 ms dwell; `pat_go`=0010 about 2 ms after the finish; `active_idx`=1.
- Pattern 3 finishes: `active_idx` wraps to 0 and `pat_go`=0001.
- Pattern 1 never finishes: after 20 ms, `timeout_err`=1 (sticky), GAP is entered, `pat_go`=0100 follows.
- Pattern 0 toggles light1 every clk in RUN: `lights[0]` changes at most once per 3 ms.
- Drop `enable` in RUN at `active_idx`=2: state goes to IDLE and `lights` dwell to 0x00. Re-enable: `pat_go`=0100.
